// File: rtl/div_sequencer.sv
// Restoring shift-subtract divider for div/divu/rem/remu; 34 cycles accept-to-valid (1 for divide by zero).
// No backpressure: ready_o only in IDLE, start ignored otherwise; flush_i aborts in any state and wins over start.
module div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q;
    logic [1:0]            op_q;
    logic                  sa_q;
    logic                  sb_q;
    logic [DATA_WIDTH-1:0] bmag_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH:0]   rem_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] res_q;

    // op bit 0 clear means a signed operation
    logic                  signed_in;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;

    assign signed_in = ~op_i[0];
    assign a_neg     = signed_in & a_i[DATA_WIDTH-1];
    assign b_neg     = signed_in & b_i[DATA_WIDTH-1];
    assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

    // Remainder shifted left with the next dividend bit, then a trial subtract one bit wider for the sign.
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] diff;
    logic                  keep;

    assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff    = shifted - {2'b00, bmag_q};
    assign keep    = ~diff[DATA_WIDTH+1];

    logic                  signed_q;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;

    assign signed_q = ~op_q[0];
    assign q_fix    = (signed_q & (sa_q ^ sb_q)) ? (~quo_q + 1'b1) : quo_q;
    assign r_fix    = (signed_q & sa_q) ? (~rem_q[DATA_WIDTH-1:0] + 1'b1) : rem_q[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bmag_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q   <= op_i;
                        sa_q   <= a_neg;
                        sb_q   <= b_neg;
                        bmag_q <= b_mag;
                        quo_q  <= a_mag;
                        rem_q  <= '0;
                        cnt_q  <= CW'(DATA_WIDTH);
                        if (b_i == '0) begin
                            // Divide by zero: quotient all ones, remainder is the raw dividend.
                            res_q   <= op_i[1] ? a_i : '1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= keep ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
                    quo_q <= {quo_q[DATA_WIDTH-2:0], keep};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_q   <= op_q[1] ? r_fix : q_fix;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE) & ~flush_i;
    assign res_o   = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus flush/reset/back-to-back sequences.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        valid;
    logic [31:0] res;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;

    div_sequencer #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .ready_o (ready),
        .valid_o (valid),
        .res_o   (res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (valid) vcount++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for valid; lat counts negedges after the accept edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output logic ready_low);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'h1234_5678; b = 32'h0000_0003; op = 2'b10;
        lat = 1;
        ready_low = 1'b1;
        while (!valid && lat < 100) begin
            if (ready) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = res;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] prev;
        logic        rl;
        int          lat;
        int          v0;

        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2};
        vecs[2]  = '{2'b00, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF};
        vecs[4]  = '{2'b10, 32'd7,         32'hFFFFFFFE,  32'd1};
        vecs[5]  = '{2'b01, 32'd5,         32'd0,         32'hFFFFFFFF};
        vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5};
        vecs[7]  = '{2'b00, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000};
        vecs[9]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0};
        vecs[10] = '{2'b01, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF};
        vecs[11] = '{2'b10, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB};
        vecs[12] = '{2'b00, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2};
        vecs[13] = '{2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE};
        vecs[14] = '{2'b01, 32'h80000000,  32'd3,         32'h2AAAAAAA};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset valid", 32'(valid), 32'd0);
        check("reset res", res, 32'd0);

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, rl);
            check($sformatf("vec%0d res", i), r, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), (vecs[i].b == 32'd0) ? 32'd1 : 32'd34);
            check($sformatf("vec%0d ready low while busy", i), 32'(rl), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d valid one cycle", i), 32'(valid), 32'd0);
            check($sformatf("vec%0d ready back", i), 32'(ready), 32'd1);
        end

        // Flush on the 10th cycle of CALC.
        prev = res;
        v0 = vcount;
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush ready", 32'(ready), 32'd1);
        check("flush res kept", res, prev);
        repeat (40) @(negedge clk);
        check("flush no valid", 32'(vcount - v0), 32'd0);

        // start held with changing operands while busy.
        v0 = vcount;
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        op = 2'b11; a = 32'd50; b = 32'd5;
        lat = 1;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("held start res", res, 32'd14);
        check("held start latency", 32'(lat), 32'd34);
        @(negedge clk);
        check("held start ready", 32'(ready), 32'd1);
        check("held start one valid", 32'(vcount - v0), 32'd1);

        // flush together with start in IDLE.
        prev = res;
        v0 = vcount;
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush+start not accepted", 32'(ready), 32'd1);
        repeat (40) @(negedge clk);
        check("flush+start no valid", 32'(vcount - v0), 32'd0);
        check("flush+start res kept", res, prev);

        // flush in the DONE cycle suppresses valid.
        v0 = vcount;
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);
        flush = 1'b1;
        #1;
        check("done flush valid gated", 32'(valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("done flush ready", 32'(ready), 32'd1);
        check("done flush no valid", 32'(vcount - v0), 32'd0);

        // reset mid-CALC.
        v0 = vcount;
        @(negedge clk);
        op = 2'b00; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset res", res, 32'd0);
        check("midreset ready", 32'(ready), 32'd1);
        check("midreset valid", 32'(valid), 32'd0);
        repeat (40) @(negedge clk);
        check("midreset no valid", 32'(vcount - v0), 32'd0);
        do_op(2'b01, 32'd100, 32'd7, r, lat, rl);
        check("post reset res", r, 32'd14);
        check("post reset latency", 32'(lat), 32'd34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
